// File: rtl/sccb_arbiter.sv
// sccb_arbiter
//   Shares one SCCB master between NUM_REQ requesters. Each requester holds a
//   level request; the arbiter picks one round-robin, latches its payload,
//   issues it to the master, waits for the master to finish (or time out),
//   then returns a one-cycle completion pulse to that requester.
//
// Ports
//   clk, reset         single clock, synchronous active-high reset
//   req_start          per-requester level request (held until req_done)
//   req_devaddr        packed 8-bit device addresses, slice i = [8*i+7:8*i]
//   req_regaddr        packed REGADDR_WIDTH-bit register addresses
//   req_wrdata         packed 8-bit write data
//   req_done, req_err  one-cycle completion / timeout flag to the owner
//   grant              one-hot current owner, zero when idle
//   busy               high whenever a transaction is in flight
//   sccb_start         level start to the master
//   sccb_devaddr/sccb_regaddr/sccb_wrdata  latched payload of the owner
//   sccb_done          master status: high idle, low busy, high again when done
module sccb_arbiter #(
  parameter int unsigned NUM_REQ        = 4,
  parameter int unsigned REGADDR_WIDTH  = 8,
  parameter int unsigned TIMEOUT_CYCLES = 65535
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [NUM_REQ-1:0]               req_start,
  input  logic [8*NUM_REQ-1:0]             req_devaddr,
  input  logic [REGADDR_WIDTH*NUM_REQ-1:0] req_regaddr,
  input  logic [8*NUM_REQ-1:0]             req_wrdata,
  output logic [NUM_REQ-1:0]               req_done,
  output logic [NUM_REQ-1:0]               req_err,
  output logic [NUM_REQ-1:0]               grant,
  output logic                             busy,
  output logic                             sccb_start,
  output logic [7:0]                       sccb_devaddr,
  output logic [REGADDR_WIDTH-1:0]         sccb_regaddr,
  output logic [7:0]                       sccb_wrdata,
  input  logic                             sccb_done
);

  localparam int unsigned IDX_W         = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [15:0] TIMEOUT_MATCH = 16'(TIMEOUT_CYCLES);

  localparam logic [1:0] S_IDLE      = 2'd0;
  localparam logic [1:0] S_ISSUE     = 2'd1;
  localparam logic [1:0] S_WAIT_DONE = 2'd2;
  localparam logic [1:0] S_ACK       = 2'd3;

  logic [1:0]               state;
  logic [IDX_W-1:0]         last_grant;
  logic [IDX_W-1:0]         owner;
  logic [15:0]              timeout_cnt;
  logic [15:0]              timeout_cnt_next;
  logic                     timeout_hit;
  logic                     ack_err;

  logic                     any_req;
  logic [IDX_W-1:0]         rr_sel;
  int unsigned              rr_cand;
  logic [7:0]               sel_devaddr;
  logic [REGADDR_WIDTH-1:0] sel_regaddr;
  logic [7:0]               sel_wrdata;

  // Round-robin: walk offsets 1..NUM_REQ past last_grant, first live request wins.
  always_comb begin
    any_req = 1'b0;
    rr_sel  = '0;
    rr_cand = 0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      rr_cand = (32'(last_grant) + k) % NUM_REQ;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        if (!any_req && (i == rr_cand) && req_start[i]) begin
          any_req = 1'b1;
          rr_sel  = IDX_W'(i);
        end
      end
    end
  end

  always_comb begin
    sel_devaddr = '0;
    sel_regaddr = '0;
    sel_wrdata  = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (rr_sel == IDX_W'(i)) begin
        sel_devaddr = req_devaddr[8*i +: 8];
        sel_regaddr = req_regaddr[REGADDR_WIDTH*i +: REGADDR_WIDTH];
        sel_wrdata  = req_wrdata[8*i +: 8];
      end
    end
  end

  // The match is taken on the incremented value so ACK is entered exactly
  // TIMEOUT_CYCLES cycles after the first ISSUE cycle.
  assign timeout_cnt_next = timeout_cnt + 16'd1;
  assign timeout_hit      = (timeout_cnt_next == TIMEOUT_MATCH);

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= S_IDLE;
      grant        <= '0;
      owner        <= '0;
      last_grant   <= IDX_W'(NUM_REQ - 1);
      timeout_cnt  <= '0;
      ack_err      <= 1'b0;
      sccb_devaddr <= '0;
      sccb_regaddr <= '0;
      sccb_wrdata  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (any_req) begin
            state        <= S_ISSUE;
            owner        <= rr_sel;
            grant        <= NUM_REQ'(1) << rr_sel;
            sccb_devaddr <= sel_devaddr;
            sccb_regaddr <= sel_regaddr;
            sccb_wrdata  <= sel_wrdata;
            timeout_cnt  <= '0;
            ack_err      <= 1'b0;
          end
        end
        S_ISSUE: begin
          timeout_cnt <= timeout_cnt_next;
          if (timeout_hit) begin
            state   <= S_ACK;
            ack_err <= 1'b1;
          end else if (!sccb_done) begin
            state <= S_WAIT_DONE;
          end
        end
        S_WAIT_DONE: begin
          timeout_cnt <= timeout_cnt_next;
          // Completion beats a coincident timeout.
          if (sccb_done) begin
            state <= S_ACK;
          end else if (timeout_hit) begin
            state   <= S_ACK;
            ack_err <= 1'b1;
          end
        end
        S_ACK: begin
          state      <= S_IDLE;
          grant      <= '0;
          last_grant <= owner;
          ack_err    <= 1'b0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    busy       = (state != S_IDLE);
    sccb_start = (state == S_ISSUE);
    req_done   = (state == S_ACK) ? grant : '0;
    req_err    = ((state == S_ACK) && ack_err) ? grant : '0;
  end

endmodule

// File: tb/tb_sccb_arbiter.sv
// Bench for sccb_arbiter: directed scenarios with literal expectations plus a
// randomized run, all cross-checked every cycle against a transaction-level model.
module tb_sccb_arbiter;
  localparam int NR = 4;
  localparam int RW = 8;
  localparam int TO = 100;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [NR-1:0]     req_start = '0;
  logic [8*NR-1:0]   req_devaddr = '0;
  logic [RW*NR-1:0]  req_regaddr = '0;
  logic [8*NR-1:0]   req_wrdata = '0;
  logic [NR-1:0]     req_done, req_err, grant;
  logic              busy, sccb_start;
  logic              sccb_done = 1'b1;
  logic [7:0]        sccb_devaddr, sccb_wrdata;
  logic [RW-1:0]     sccb_regaddr;

  sccb_arbiter #(.NUM_REQ(NR), .REGADDR_WIDTH(RW), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset), .req_start(req_start), .req_devaddr(req_devaddr),
    .req_regaddr(req_regaddr), .req_wrdata(req_wrdata), .req_done(req_done),
    .req_err(req_err), .grant(grant), .busy(busy), .sccb_start(sccb_start),
    .sccb_devaddr(sccb_devaddr), .sccb_regaddr(sccb_regaddr),
    .sccb_wrdata(sccb_wrdata), .sccb_done(sccb_done)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;
  int cyc = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // ---------------- transaction-level reference model ----------------
  // owner < 0 means nobody holds the master; age counts cycles since the grant;
  // seen_low records that the master has gone busy; ending marks the pulse cycle.
  bit          mdl_valid = 0;
  int          m_owner, m_age, m_last;
  bit          m_low, m_end, m_err;
  logic [7:0]  m_dev, m_wr;
  logic [RW-1:0] m_reg;

  task automatic model_step();
    int pick;
    cyc++;
    if (reset) begin
      mdl_valid = 1; m_owner = -1; m_last = NR - 1; m_age = 0;
      m_low = 0; m_end = 0; m_err = 0; m_dev = '0; m_wr = '0; m_reg = '0;
      return;
    end
    if (!mdl_valid) return;
    if (m_owner < 0) begin
      pick = -1;
      for (int k = 1; k <= NR; k++)
        if (pick < 0 && req_start[(m_last + k) % NR]) pick = (m_last + k) % NR;
      if (pick >= 0) begin
        m_owner = pick; m_age = 0; m_low = 0; m_end = 0; m_err = 0;
        m_dev = req_devaddr[8*pick +: 8];
        m_reg = req_regaddr[RW*pick +: RW];
        m_wr  = req_wrdata[8*pick +: 8];
      end
    end else if (m_end) begin
      m_last = m_owner; m_owner = -1; m_end = 0; m_err = 0;
    end else begin
      m_age++;
      if (m_low && sccb_done) m_end = 1;
      else if (m_age == TO) begin m_end = 1; m_err = 1; end
      else if (!m_low && !sccb_done) m_low = 1;
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  // Per-cycle compare against the model.
  initial forever begin
    logic [NR-1:0] eg;
    @(negedge clk);
    if (mdl_valid) begin
      eg = (m_owner >= 0) ? (NR'(1) << m_owner) : '0;
      chk("grant", 32'(grant), 32'(eg));
      chk("busy", 32'(busy), 32'(m_owner >= 0));
      chk("sccb_start", 32'(sccb_start), 32'(m_owner >= 0 && !m_low && !m_end));
      chk("req_done", 32'(req_done), m_end ? 32'(eg) : 32'd0);
      chk("req_err", 32'(req_err), (m_end && m_err) ? 32'(eg) : 32'd0);
      chk("sccb_devaddr", 32'(sccb_devaddr), 32'(m_dev));
      chk("sccb_regaddr", 32'(sccb_regaddr), 32'(m_reg));
      chk("sccb_wrdata", 32'(sccb_wrdata), 32'(m_wr));
    end
  end

  // ---------------- SCCB master emulation ----------------
  int mst_d1 = 1, mst_d2 = 5, mst_phase = 0, mst_cnt = 0;
  bit mst_hang = 0, mst_rand = 0;

  initial forever begin
    bit hang;
    @(posedge clk); #2;
    if (reset) begin
      sccb_done = 1'b1; mst_phase = 0;
    end else begin
      if (mst_phase == 0 && sccb_start) begin
        if (mst_rand) begin
          mst_d1 = $urandom_range(0, 3);
          mst_d2 = ($urandom_range(0, 9) == 0) ? $urandom_range(90, 110) : $urandom_range(0, 30);
          hang   = ($urandom_range(0, 19) == 0);
        end else hang = mst_hang;
        if (hang) mst_phase = 3;
        else begin mst_cnt = mst_d1; mst_phase = 1; end
      end
      if (mst_phase == 1) begin
        if (mst_cnt == 0) begin sccb_done = 1'b0; mst_cnt = mst_d2; mst_phase = 2; end
        else mst_cnt--;
      end else if (mst_phase == 2) begin
        if (mst_cnt == 0) begin sccb_done = 1'b1; mst_phase = 0; end
        else mst_cnt--;
      end else if (mst_phase == 3 && !sccb_start) mst_phase = 0;
    end
  end

  // ---------------- helpers ----------------
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic wait_grant(input int maxc, output int gc, output logic [NR-1:0] g);
    gc = -1; g = '0;
    for (int k = 0; k < maxc; k++) begin
      @(negedge clk);
      if (grant != '0) begin gc = cyc; g = grant; return; end
    end
    n_vec++; n_bad++;
    $display("FAIL wait_grant: no grant within %0d cycles", maxc);
  endtask

  task automatic wait_done(input int maxc, output int dc, output logic [NR-1:0] d,
                           output logic [NR-1:0] e);
    dc = -1; d = '0; e = '0;
    for (int k = 0; k < maxc; k++) begin
      @(negedge clk);
      if (req_done != '0) begin dc = cyc; d = req_done; e = req_err; return; end
    end
    n_vec++; n_bad++;
    $display("FAIL wait_done: no req_done within %0d cycles", maxc);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    int gc, dc, dcy;
    logic [NR-1:0] g, d, e;
    logic [NR-1:0] exp_order [5];
    exp_order = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

    // Reset state
    tick(); tick();
    @(negedge clk);
    chk("rst_grant", 32'(grant), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_start", 32'(sccb_start), 0);
    chk("rst_wrdata", 32'(sccb_wrdata), 0);
    tick(); reset = 1'b0;

    // Single request, payload 42/12/80, master busy 2 cycles after start for 20 cycles
    tick();
    req_devaddr[7:0] = 8'h42; req_regaddr[7:0] = 8'h12; req_wrdata[7:0] = 8'h80;
    mst_d1 = 2; mst_d2 = 19;
    req_start = 4'b0001; dcy = cyc;
    wait_grant(5, gc, g);
    chk("single_latency", 32'(gc - dcy), 1);
    chk("single_grant", 32'(g), 32'h1);
    chk("single_start", 32'(sccb_start), 1);
    chk("single_dev", 32'(sccb_devaddr), 32'h42);
    chk("single_reg", 32'(sccb_regaddr), 32'h12);
    chk("single_wr", 32'(sccb_wrdata), 32'h80);
    wait_done(200, dc, d, e);
    chk("single_done", 32'(d), 32'h1);
    chk("single_err", 32'(e), 0);
    chk("single_done_cycle", 32'(dc - gc), 23);
    tick(); req_start = '0;
    @(negedge clk);
    chk("single_done_once", 32'(req_done), 0);

    // Contention from reset: order 0,1,2,3,0
    tick(); reset = 1'b1; tick(); reset = 1'b0;
    mst_d1 = 0; mst_d2 = 3;
    req_start = '1;
    for (int r = 0; r < 5; r++) begin
      wait_done(300, dc, d, e);
      chk("rr_order", 32'(d), 32'(exp_order[r]));
    end
    tick(); req_start = '0;
    tick(); tick();

    // Timeout with sccb_done stuck high; request dropped after grant
    mst_hang = 1;
    req_start = 4'b0100;
    wait_grant(5, gc, g);
    chk("to_grant", 32'(g), 32'h4);
    tick(); req_start = '0;
    wait_done(300, dc, d, e);
    chk("to_done", 32'(d), 32'h4);
    chk("to_err", 32'(e), 32'h4);
    chk("to_cycles", 32'(dc - gc), 100);
    chk("to_start_low", 32'(sccb_start), 0);
    mst_hang = 0;
    tick(); tick();

    // Tie: master finishes on the very cycle the timeout matches -> success
    mst_d1 = 0; mst_d2 = 98;
    req_start = 4'b1000;
    wait_grant(5, gc, g);
    tick(); req_start = '0;
    wait_done(300, dc, d, e);
    chk("tie_done", 32'(d), 32'h8);
    chk("tie_err", 32'(e), 0);
    chk("tie_cycles", 32'(dc - gc), 100);
    tick(); tick();

    // One cycle too late -> timeout
    mst_d2 = 99;
    req_start = 4'b0001;
    wait_grant(5, gc, g);
    tick(); req_start = '0;
    wait_done(300, dc, d, e);
    chk("late_err", 32'(e), 32'h1);
    chk("late_cycles", 32'(dc - gc), 100);
    tick(); tick(); tick();

    // Payload stability, then reset mid WAIT_DONE
    mst_d1 = 0; mst_d2 = 50;
    req_wrdata[23:16] = 8'h5A;
    req_start = 4'b0100;
    wait_grant(5, gc, g);
    chk("hold_wr_latched", 32'(sccb_wrdata), 32'h5A);
    repeat (10) tick();
    req_wrdata[23:16] = 8'hA5;
    @(negedge clk);
    chk("hold_wr_stable", 32'(sccb_wrdata), 32'h5A);
    chk("hold_busy", 32'(busy), 1);
    tick(); reset = 1'b1; req_start = '0;
    tick(); reset = 1'b0;
    @(negedge clk);
    chk("rstmid_grant", 32'(grant), 0);
    chk("rstmid_busy", 32'(busy), 0);
    chk("rstmid_done", 32'(req_done), 0);
    tick(); req_start = 4'b1001;
    wait_grant(5, gc, g);
    chk("rstmid_first", 32'(g), 32'h1);
    tick(); req_start = '0;
    wait_done(200, dc, d, e);
    chk("rstmid_done0", 32'(d), 32'h1);
    repeat (3) tick();
    @(negedge clk);
    chk("dropped_not_served", 32'(grant), 0);

    // Randomized traffic
    mst_rand = 1;
    for (int c = 0; c < 3000; c++) begin
      tick();
      reset = ($urandom_range(0, 599) == 0);
      for (int i = 0; i < NR; i++) begin
        if (req_done[i] && $urandom_range(0, 1) == 1) req_start[i] = 1'b0;
        else if (!req_start[i] && $urandom_range(0, 7) == 0) begin
          req_start[i] = 1'b1;
          req_devaddr[8*i +: 8] = 8'($urandom);
          req_regaddr[RW*i +: RW] = RW'($urandom);
          req_wrdata[8*i +: 8] = 8'($urandom);
        end else if (req_start[i] && $urandom_range(0, 63) == 0) req_start[i] = 1'b0;
        if ($urandom_range(0, 15) == 0) req_wrdata[8*i +: 8] = 8'($urandom);
      end
    end
    reset = 1'b0; req_start = '0;
    repeat (300) tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
